// File: rtl/mod_memstage_if.sv
// mod_memstage_if: single-outstanding memory bus between the memory stage and memory
interface mod_memstage_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;
   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
   modport slave (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mod_memstage.sv
// mod_memstage: memory-access stage between execute and writeback
module mod_memstage #(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [7:0]        ex_opcode,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic [DATA_W-1:0] ex_alu_ext_result,
   input  logic [DATA_W-1:0] ex_data_regB,
   input  logic [3:0]        ex_regByte,
   input  logic [3:0]        ex_rmByte,
   input  logic              ex_sim_end,
   mod_memstage_if.master    mem,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [7:0]        wb_opcode,
   output logic [DATA_W-1:0] wb_alu_result,
   output logic [DATA_W-1:0] wb_alu_ext_result,
   output logic [3:0]        wb_regByte,
   output logic [3:0]        wb_rmByte,
   output logic              wb_sim_end,
   output logic              store_memstage_active,
   output logic              mem_err
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, OUT} state_t;
   state_t            state, state_n;
   logic [7:0]        cnt, l_op;
   logic [DATA_W-1:0] l_alu, l_ext, l_b, wb_res;
   logic [3:0]        l_reg, l_rm;
   logic              l_end, l_st;
   logic              ex_ld, ex_st, ex_pass, accept, busy, busy_n, tmo, abort, enter_out;

   assign ex_ld     = ex_opcode == 8'h8B;
   assign ex_st     = ex_opcode == 8'h89 || ex_opcode == 8'hFF;
   assign ex_pass   = !ex_ld && !ex_st;
   assign ex_ready  = state == IDLE && (!wb_valid || wb_ready);
   assign accept    = ex_valid && ex_ready;
   assign busy      = state == REQ || state == WAIT_R;
   assign busy_n    = state_n == REQ || state_n == WAIT_R;
   assign enter_out = busy && state_n == OUT;
   assign tmo       = TIMEOUT != 0 && cnt + 8'd1 == 8'(TIMEOUT);
   assign wb_res    = l_st ? l_alu : (state == WAIT_R && mem.rvalid) ? mem.rdata : '0;
   assign mem.req   = state == REQ;
   assign mem.we    = state == REQ && l_st;
   assign mem.addr  = ADDR_W'(l_alu);
   assign mem.wdata = l_b;

   // next state; a grant or response wins over a timeout in the same cycle
   always_comb begin
      state_n = state;
      abort   = 1'b0;
      unique case (state)
         IDLE:    state_n = accept && !ex_pass ? REQ : IDLE;
         REQ: begin
            state_n = mem.gnt ? (l_st ? OUT : WAIT_R) : tmo ? OUT : REQ;
            abort   = !mem.gnt && tmo;
         end
         WAIT_R: begin
            state_n = mem.rvalid || tmo ? OUT : WAIT_R;
            abort   = !mem.rvalid && tmo;
         end
         default: state_n = IDLE;
      endcase
   end

   // state register, bus wait counter and sticky timeout flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         mem_err <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= busy && busy_n ? cnt + 8'd1 : '0;
         mem_err <= mem_err | abort;
      end
   end

   // capture the execute op on acceptance for use during the bus transaction
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         l_op  <= '0;
         l_alu <= '0;
         l_ext <= '0;
         l_b   <= '0;
         l_reg <= '0;
         l_rm  <= '0;
         l_end <= 1'b0;
         l_st  <= 1'b0;
      end else if (accept) begin
         l_op  <= ex_opcode;
         l_alu <= ex_alu_result;
         l_ext <= ex_alu_ext_result;
         l_b   <= ex_data_regB;
         l_reg <= ex_regByte;
         l_rm  <= ex_rmByte;
         l_end <= ex_sim_end;
         l_st  <= ex_st;
      end
   end

   // writeback register: pass ops load directly, memory ops load on entering OUT
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_valid              <= 1'b0;
         wb_opcode             <= '0;
         wb_alu_result         <= '0;
         wb_alu_ext_result     <= '0;
         wb_regByte            <= '0;
         wb_rmByte             <= '0;
         wb_sim_end            <= 1'b0;
         store_memstage_active <= 1'b0;
      end else if (accept && ex_pass) begin
         wb_valid              <= 1'b1;
         wb_opcode             <= ex_opcode;
         wb_alu_result         <= ex_alu_result;
         wb_alu_ext_result     <= ex_alu_ext_result;
         wb_regByte            <= ex_regByte;
         wb_rmByte             <= ex_rmByte;
         wb_sim_end            <= ex_sim_end;
         store_memstage_active <= 1'b0;
      end else if (enter_out) begin
         wb_valid              <= 1'b1;
         wb_opcode             <= l_op;
         wb_alu_result         <= wb_res;
         wb_alu_ext_result     <= l_ext;
         wb_regByte            <= l_reg;
         wb_rmByte             <= l_rm;
         wb_sim_end            <= l_end;
         store_memstage_active <= l_st;
      end else if (wb_ready) begin
         wb_valid              <= 1'b0;
         store_memstage_active <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mod_memstage.sv
// tb_mod_memstage: directed checks of the memory stage (timeout set to 4 cycles)
module tb_mod_memstage;
   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid, ex_ready, ex_sim_end;
   logic [7:0]  ex_opcode;
   logic [63:0] ex_alu_result, ex_alu_ext_result, ex_data_regB;
   logic [3:0]  ex_regByte, ex_rmByte;
   logic        wb_valid, wb_ready, wb_sim_end, store_memstage_active, mem_err;
   logic [7:0]  wb_opcode;
   logic [63:0] wb_alu_result, wb_alu_ext_result;
   logic [3:0]  wb_regByte, wb_rmByte;
   int          vectors = 0;
   int          miscompares = 0;

   mod_memstage_if #(.ADDR_W(64), .DATA_W(64)) mem ();

   mod_memstage #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
      .ex_alu_result(ex_alu_result), .ex_alu_ext_result(ex_alu_ext_result),
      .ex_data_regB(ex_data_regB), .ex_regByte(ex_regByte), .ex_rmByte(ex_rmByte),
      .ex_sim_end(ex_sim_end), .mem(mem.master),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_opcode(wb_opcode),
      .wb_alu_result(wb_alu_result), .wb_alu_ext_result(wb_alu_ext_result),
      .wb_regByte(wb_regByte), .wb_rmByte(wb_rmByte), .wb_sim_end(wb_sim_end),
      .store_memstage_active(store_memstage_active), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic offer(input logic [7:0] op, input logic [63:0] alu, input logic [63:0] b);
      ex_valid = 1'b1; ex_opcode = op; ex_alu_result = alu; ex_data_regB = b;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; ex_valid = 1'b0; ex_opcode = '0; ex_alu_result = '0; ex_alu_ext_result = '0;
      ex_data_regB = '0; ex_regByte = '0; ex_rmByte = '0; ex_sim_end = 1'b0; wb_ready = 1'b0;
      mem.gnt = 1'b0; mem.rvalid = 1'b0; mem.rdata = '0;
      #1;
      chk("rst_ex_ready", ex_ready, 1);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_mem_req", mem.req, 0);
      chk("rst_mem_err", mem_err, 0);
      chk("rst_store_act", store_memstage_active, 0);
      @(negedge clk); reset = 1'b1; wb_ready = 1'b1;
      // pass op, back-to-back
      offer(8'h01, 64'h5, 0); ex_alu_ext_result = 64'h7; ex_regByte = 4'h3; ex_rmByte = 4'h4; ex_sim_end = 1'b1;
      @(negedge clk);
      chk("pass1_valid", wb_valid, 1);
      chk("pass1_alu", wb_alu_result, 64'h5);
      chk("pass1_ext", wb_alu_ext_result, 64'h7);
      chk("pass1_reg", wb_regByte, 4'h3);
      chk("pass1_rm", wb_rmByte, 4'h4);
      chk("pass1_end", wb_sim_end, 1);
      chk("pass1_store", store_memstage_active, 0);
      chk("pass1_ready", ex_ready, 1);
      offer(8'h02, 64'h9, 0); ex_sim_end = 1'b0;
      @(negedge clk);
      chk("pass2_alu", wb_alu_result, 64'h9);
      chk("pass2_op", wb_opcode, 8'h02);
      chk("pass2_end", wb_sim_end, 0);
      ex_valid = 1'b0;
      @(negedge clk);
      chk("pass_drain", wb_valid, 0);
      // load, grant in the second request cycle, data the cycle after
      offer(8'h8B, 64'h1000, 0);
      @(negedge clk); ex_valid = 1'b0;
      chk("ld_req1", mem.req, 1);
      chk("ld_addr1", mem.addr, 64'h1000);
      chk("ld_we1", mem.we, 0);
      chk("ld_ready1", ex_ready, 0);
      @(negedge clk);
      chk("ld_req2", mem.req, 1);
      chk("ld_addr2", mem.addr, 64'h1000);
      chk("ld_we2", mem.we, 0);
      mem.gnt = 1'b1;
      @(negedge clk); mem.gnt = 1'b0;
      chk("ld_req_drop", mem.req, 0);
      chk("ld_ready_w", ex_ready, 0);
      chk("ld_wbv_w", wb_valid, 0);
      mem.rvalid = 1'b1; mem.rdata = 64'hDEADBEEF;
      @(negedge clk); mem.rvalid = 1'b0;
      chk("ld_valid", wb_valid, 1);
      chk("ld_data", wb_alu_result, 64'hDEADBEEF);
      chk("ld_op", wb_opcode, 8'h8B);
      chk("ld_store", store_memstage_active, 0);
      chk("ld_ready_o", ex_ready, 0);
      @(negedge clk);
      chk("ld_idle", ex_ready, 1);
      // grant and rvalid together count as grant only
      offer(8'h8B, 64'h3000, 0);
      @(negedge clk); ex_valid = 1'b0;
      mem.gnt = 1'b1; mem.rvalid = 1'b1; mem.rdata = 64'h111;
      @(negedge clk); mem.gnt = 1'b0; mem.rvalid = 1'b0;
      chk("sim_wbv", wb_valid, 0);
      chk("sim_req", mem.req, 0);
      @(negedge clk);
      chk("sim_wait", wb_valid, 0);
      mem.rvalid = 1'b1; mem.rdata = 64'h222;
      @(negedge clk); mem.rvalid = 1'b0;
      chk("sim_valid", wb_valid, 1);
      chk("sim_data", wb_alu_result, 64'h222);
      chk("sim_err", mem_err, 0);
      @(negedge clk);
      // store 0x89, immediate grant
      offer(8'h89, 64'h2000, 64'h42);
      @(negedge clk); ex_valid = 1'b0;
      chk("st_req", mem.req, 1);
      chk("st_we", mem.we, 1);
      chk("st_wdata", mem.wdata, 64'h42);
      chk("st_addr", mem.addr, 64'h2000);
      mem.gnt = 1'b1;
      @(negedge clk); mem.gnt = 1'b0;
      chk("st_valid", wb_valid, 1);
      chk("st_active", store_memstage_active, 1);
      chk("st_alu", wb_alu_result, 64'h2000);
      chk("st_req_drop", mem.req, 0);
      @(negedge clk);
      chk("st_clear", store_memstage_active, 0);
      // store 0xFF
      offer(8'hFF, 64'h40, 64'h77);
      @(negedge clk); ex_valid = 1'b0;
      chk("stff_we", mem.we, 1);
      chk("stff_wdata", mem.wdata, 64'h77);
      mem.gnt = 1'b1;
      @(negedge clk); mem.gnt = 1'b0;
      chk("stff_active", store_memstage_active, 1);
      @(negedge clk);
      // writeback stall with a new op offered
      wb_ready = 1'b0;
      offer(8'h05, 64'hAA, 0);
      @(negedge clk);
      chk("stall_load", wb_alu_result, 64'hAA);
      offer(8'h06, 64'hBB, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_alu", wb_alu_result, 64'hAA);
         chk("stall_op", wb_opcode, 8'h05);
         chk("stall_valid", wb_valid, 1);
         chk("stall_ready", ex_ready, 0);
      end
      wb_ready = 1'b1; #1;
      chk("stall_release", ex_ready, 1);
      @(negedge clk); ex_valid = 1'b0;
      chk("stall_next", wb_alu_result, 64'hBB);
      @(negedge clk);
      chk("stall_drain", wb_valid, 0);
      // load never granted times out after 4 request cycles
      offer(8'h8B, 64'h5000, 0);
      @(negedge clk); ex_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("to_req", mem.req, 1);
         chk("to_err_pre", mem_err, 0);
         @(negedge clk);
      end
      chk("to_err", mem_err, 1);
      chk("to_valid", wb_valid, 1);
      chk("to_data", wb_alu_result, 0);
      chk("to_req_drop", mem.req, 0);
      @(negedge clk);
      chk("to_idle", ex_ready, 1);
      chk("to_sticky", mem_err, 1);
      // reset asserted during a request cycle drops mem_req at once
      offer(8'h8B, 64'h7000, 0);
      @(negedge clk); ex_valid = 1'b0;
      chk("rq_req", mem.req, 1);
      #2 reset = 1'b0; #1;
      chk("rq_rst_req", mem.req, 0);
      chk("rq_rst_err", mem_err, 0);
      @(negedge clk); reset = 1'b1;
      // reset asserted in WAIT_R, late rvalid ignored
      offer(8'h8B, 64'h6000, 0);
      @(negedge clk); ex_valid = 1'b0; mem.gnt = 1'b1;
      @(negedge clk); mem.gnt = 1'b0;
      chk("wr_ready_pre", ex_ready, 0);
      #2 reset = 1'b0; #1;
      chk("wr_rst_req", mem.req, 0);
      chk("wr_rst_valid", wb_valid, 0);
      chk("wr_rst_ready", ex_ready, 1);
      @(negedge clk); reset = 1'b1;
      mem.rvalid = 1'b1; mem.rdata = 64'h999;
      @(negedge clk); mem.rvalid = 1'b0;
      chk("late_valid", wb_valid, 0);
      chk("late_alu", wb_alu_result, 0);
      chk("late_ready", ex_ready, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
